// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity mode encodings and the
// transmit FSM state enumeration.
package uart_pkg;

  // parity_mode encodings; ParRsvd is treated the same as ParNone
  localparam logic [1:0] ParNone = 2'b00;
  localparam logic [1:0] ParEven = 2'b01;
  localparam logic [1:0] ParOdd  = 2'b10;
  localparam logic [1:0] ParRsvd = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous single-clock FIFO holding words waiting to be transmitted.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (flushes contents)
//   push_i/push_data_i  write request and data (ignored while full)
//   pop_i/pop_data_o    read request and head-of-queue data (ignored while empty)
//   full_o, empty_o, count_o  registered status
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CntW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;

endmodule

// File: rtl/uart_xmtr_param.sv
// Parameterised UART transmitter with a holding FIFO.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   baud_div_i            bit period minus one, in clock cycles
//   parity_mode_i         00 none, 01 even, 10 odd, 11 none
//   two_stop_i            1 = two stop bits
//   tx_data_i/tx_valid_i  word to queue; tx_ready_o = FIFO not full (0 in reset)
//   serial_out_o          registered serial line, idle high
//   busy_o                frame in progress or words queued
//   fifo_count_o          words held in the FIFO
module uart_xmtr_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic [1:0]                    parity_mode_i,
  input  logic                          two_stop_i,
  input  logic [DATA_W-1:0]             tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          serial_out_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned BitW = 4;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  logic              fifo_full, fifo_empty, pop;
  logic [DATA_W-1:0] fifo_rdata;

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [1:0]        mode_q, mode_d;
  logic              two_q, two_d;
  logic              serial_q, serial_d;
  logic              bit_end, par_en, load;

  assign tx_ready_o = ~fifo_full & ~rst_i;

  uart_tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (tx_valid_i & tx_ready_o),
    .push_data_i (tx_data_i),
    .pop_i       (pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count_o)
  );

  assign bit_end = (baud_q == div_q);
  assign par_en  = (mode_q == ParEven) || (mode_q == ParOdd);

  always_comb begin
    state_d  = state_q;
    baud_d   = bit_end ? '0 : baud_q + DIV_W'(1);
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    mode_d   = mode_q;
    two_d    = two_q;
    serial_d = serial_q;
    load     = 1'b0;
    pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_d   = '0;
        serial_d = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d  = StData;
          bit_d    = '0;
          serial_d = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_q == LastBit) begin
            bit_d = '0;
            if (par_en) begin
              state_d  = StParity;
              serial_d = par_q ^ shift_q[0] ^ (mode_q == ParOdd);
            end else begin
              state_d  = StStop;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + BitW'(1);
            serial_d = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d  = StStop;
          bit_d    = '0;
          serial_d = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (two_q && (bit_q == '0)) begin
            bit_d = BitW'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame settings are captured at pop so mid-frame input changes are ignored
    if (load) begin
      pop      = 1'b1;
      state_d  = StStart;
      shift_d  = fifo_rdata;
      div_d    = baud_div_i;
      mode_d   = parity_mode_i;
      two_d    = two_stop_i;
      par_d    = 1'b0;
      baud_d   = '0;
      bit_d    = '0;
      serial_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      mode_q   <= ParNone;
      two_q    <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      mode_q   <= mode_d;
      two_q    <= two_d;
      serial_q <= serial_d;
    end
  end

  assign serial_out_o = serial_q;
  assign busy_o       = !((state_q == StIdle) && (fifo_count_o == '0));

endmodule
